// File: rtl/seg7_scan_ctrl_if.sv
// Display register side of the 7-segment scanner: host-written data and
// controls in, pin-level digit select / segment bus and frame pulse out.
interface seg7_scan_ctrl_if #(
    parameter int DIGITS = 8
);
    logic [4*DIGITS-1:0] data_in;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   digit_en;
    logic [DIGITS-1:0]   blink_mask;
    logic                lz_suppress;
    // load is a one-cycle strobe with no back-pressure: the controller always
    // accepts it on the edge where it is high; the data appears from the next frame.
    logic                load;
    logic [DIGITS-1:0]   seg_en;
    logic [7:0]          seg_out;
    logic                frame_done;

    modport master (
        output data_in, dp_in, digit_en, blink_mask, lz_suppress, load,
        input  seg_en, seg_out, frame_done
    );

    modport slave (
        input  data_in, dp_in, digit_en, blink_mask, lz_suppress, load,
        output seg_en, seg_out, frame_done
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scanner with dead time, blink, leading-zero suppression
// and frame-synchronous (tear-free) display data update.
module seg7_scan_ctrl #(
    parameter int DIGITS         = 8,
    parameter int SCAN_DIV       = 100000,
    parameter int DEAD_CYC       = 1000,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int EN_ACTIVE_LOW  = 0
) (
    input logic clk,
    input logic rst,
    seg7_scan_ctrl_if.slave bus
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] C_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] I_LAST  = IW'(DIGITS - 1);
    localparam logic [FW-1:0] F_LAST  = FW'(BLINK_FRAMES - 1);
    localparam logic [CW:0]   DEAD    = (CW + 1)'(DEAD_CYC);
    localparam logic          SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic          EN_INV  = (EN_ACTIVE_LOW != 0);

    logic [CW-1:0]       c_q, c_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] stage_data_q, stage_data_d;
    logic [DIGITS-1:0]   stage_dp_q, stage_dp_d;
    logic                pending_q, pending_d;
    logic [4*DIGITS-1:0] shadow_data_q, shadow_data_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [FW-1:0]       fc_q, fc_d;
    logic                bp_q, bp_d;
    logic                frame_end;

    function automatic logic [7:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0: seg_decode = 8'hFC;
            4'h1: seg_decode = 8'h60;
            4'h2: seg_decode = 8'hDA;
            4'h3: seg_decode = 8'hF2;
            4'h4: seg_decode = 8'h66;
            4'h5: seg_decode = 8'hB6;
            4'h6: seg_decode = 8'hBE;
            4'h7: seg_decode = 8'hE0;
            4'h8: seg_decode = 8'hFE;
            4'h9: seg_decode = 8'hF6;
            4'hA: seg_decode = 8'hEE;
            4'hB: seg_decode = 8'h3E;
            4'hC: seg_decode = 8'h9C;
            4'hD: seg_decode = 8'h7A;
            4'hE: seg_decode = 8'h9E;
            default: seg_decode = 8'h8E;
        endcase
    endfunction

    always_comb begin
        frame_end     = (idx_q == I_LAST) && (c_q == C_LAST);
        c_d           = c_q + 1'b1;
        idx_d         = idx_q;
        stage_data_d  = stage_data_q;
        stage_dp_d    = stage_dp_q;
        pending_d     = pending_q;
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        fc_d          = fc_q;
        bp_d          = bp_q;
        if (c_q == C_LAST) begin
            c_d   = '0;
            idx_d = (idx_q == I_LAST) ? '0 : idx_q + 1'b1;
        end
        if (bus.load) begin
            stage_data_d = bus.data_in;
            stage_dp_d   = bus.dp_in;
            pending_d    = 1'b1;
        end
        // Shadow only changes at the frame boundary, so a frame is never mixed.
        if (frame_end) begin
            pending_d = 1'b0;
            if (bus.load) begin
                shadow_data_d = bus.data_in;
                shadow_dp_d   = bus.dp_in;
            end else if (pending_q) begin
                shadow_data_d = stage_data_q;
                shadow_dp_d   = stage_dp_q;
            end
            if (fc_q == F_LAST) begin
                fc_d = '0;
                bp_d = ~bp_q;
            end else begin
                fc_d = fc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q           <= '0;
            idx_q         <= '0;
            stage_data_q  <= '0;
            stage_dp_q    <= '0;
            pending_q     <= 1'b0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            fc_q          <= '0;
            bp_q          <= 1'b0;
        end else begin
            c_q           <= c_d;
            idx_q         <= idx_d;
            stage_data_q  <= stage_data_d;
            stage_dp_q    <= stage_dp_d;
            pending_q     <= pending_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            fc_q          <= fc_d;
            bp_q          <= bp_d;
        end
    end

    logic              show, all_zero, lit;
    logic              dp_sel, en_sel, blink_sel, supp_sel;
    logic [3:0]        nib;
    logic [DIGITS-1:0] supp, en_raw;
    logic [7:0]        seg_raw;

    always_comb begin
        all_zero  = 1'b1;
        supp      = '0;
        en_raw    = '0;
        nib       = 4'h0;
        dp_sel    = 1'b0;
        en_sel    = 1'b0;
        blink_sel = 1'b0;
        supp_sel  = 1'b0;
        show      = !rst && ({1'b0, c_q} >= DEAD);
        // Walk from the most significant digit down: suppressed while all zero so far.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (shadow_data_q[4*i +: 4] == 4'h0);
            supp[i]  = bus.lz_suppress && all_zero && (i != 0);
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib       = shadow_data_q[4*i +: 4];
                dp_sel    = shadow_dp_q[i];
                en_sel    = bus.digit_en[i];
                blink_sel = bus.blink_mask[i];
                supp_sel  = supp[i];
                en_raw[i] = show;
            end
        end
        lit     = en_sel && !(blink_sel && bp_q) && !supp_sel;
        seg_raw = (show && lit) ? (seg_decode(nib) | {7'b0, dp_sel}) : 8'h00;
    end

    assign bus.seg_en     = en_raw ^ {DIGITS{EN_INV}};
    assign bus.seg_out    = seg_raw ^ {8{SEG_INV}};
    assign bus.frame_done = !rst && frame_end;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: an active-high and an active-low instance share
// stimulus; hand-computed per-cycle expectations are queued and checked by a monitor.
module tb_seg7_scan_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   base = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    typedef struct packed {
        int         tag;
        logic [3:0] en;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    exp_t exp_a_q[$];
    exp_t exp_b_q[$];
    exp_t mon_e;

    seg7_scan_ctrl_if #(.DIGITS(4)) if_a ();
    seg7_scan_ctrl_if #(.DIGITS(4)) if_b ();

    assign if_b.data_in     = if_a.data_in;
    assign if_b.dp_in       = if_a.dp_in;
    assign if_b.digit_en    = if_a.digit_en;
    assign if_b.blink_mask  = if_a.blink_mask;
    assign if_b.lz_suppress = if_a.lz_suppress;
    assign if_b.load        = if_a.load;

    seg7_scan_ctrl #(.DIGITS(4), .SCAN_DIV(4), .DEAD_CYC(1), .BLINK_FRAMES(2),
                     .SEG_ACTIVE_LOW(0), .EN_ACTIVE_LOW(0))
        dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));

    seg7_scan_ctrl #(.DIGITS(4), .SCAN_DIV(4), .DEAD_CYC(1), .BLINK_FRAMES(2),
                     .SEG_ACTIVE_LOW(1), .EN_ACTIVE_LOW(1))
        dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic wait_to(input int k);
        while (cyc < base + k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
        if_a.data_in = d;
        if_a.dp_in   = dp;
        if_a.load    = 1'b1;
        @(posedge clk);
        #1;
        if_a.load    = 1'b0;
    endtask

    // Queue expected outputs for slot cycles k_lo..k_hi of frame f; segs = {d3,d2,d1,d0}.
    task automatic exp_frame(input bit on_b, input int f, input int k_lo, input int k_hi,
                             input logic [31:0] segs);
        logic [31:0] sv;
        exp_t        e;
        sv = segs;
        for (int k = k_lo; k <= k_hi; k++) begin
            e.tag = base + f * 16 + k;
            e.en  = ((k % 4) == 0) ? 4'b0000 : (4'b0001 << (k / 4));
            e.seg = ((k % 4) == 0) ? 8'h00 : sv[(k / 4) * 8 +: 8];
            e.fd  = (k == 15);
            if (on_b) begin
                e.en  = ~e.en;
                e.seg = ~e.seg;
                exp_b_q.push_back(e);
            end else begin
                exp_a_q.push_back(e);
            end
        end
    endtask

    task automatic exp_reset_cycle();
        exp_t e;
        e.tag = cyc; e.en = 4'b0000; e.seg = 8'h00; e.fd = 1'b0;
        exp_a_q.push_back(e);
        e.en = 4'b1111; e.seg = 8'hFF;
        exp_b_q.push_back(e);
    endtask

    // scoreboard / monitor
    task automatic compare(input string nm, input exp_t e, input logic [3:0] en,
                           input logic [7:0] seg, input logic fd);
        n_checks++;
        if (en !== e.en || seg !== e.seg || fd !== e.fd) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got en=%b seg=%h fd=%b expected en=%b seg=%h fd=%b",
                     nm, e.tag, en, seg, fd, e.en, e.seg, e.fd);
        end
    endtask

    always @(negedge clk) begin
        while (exp_a_q.size() > 0 && exp_a_q[0].tag <= cyc) begin
            mon_e = exp_a_q.pop_front();
            if (mon_e.tag < cyc) begin
                n_checks++; n_fail++;
                $display("FAIL dut_a_missed cyc=%0d got none expected check at %0d", cyc, mon_e.tag);
            end else begin
                compare("dut_a", mon_e, if_a.seg_en, if_a.seg_out, if_a.frame_done);
            end
        end
        while (exp_b_q.size() > 0 && exp_b_q[0].tag <= cyc) begin
            mon_e = exp_b_q.pop_front();
            if (mon_e.tag < cyc) begin
                n_checks++; n_fail++;
                $display("FAIL dut_b_missed cyc=%0d got none expected check at %0d", cyc, mon_e.tag);
            end else begin
                compare("dut_b", mon_e, if_b.seg_en, if_b.seg_out, if_b.frame_done);
            end
        end
    end

    // stimulus
    initial begin
        rst = 1'b1;
        if_a.data_in = '0; if_a.dp_in = '0; if_a.digit_en = 4'hF;
        if_a.blink_mask = '0; if_a.lz_suppress = 1'b0; if_a.load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_reset_cycle();
        @(posedge clk);
        #1;
        rst  = 1'b0;
        base = cyc;

        exp_frame(0, 0, 0, 15, 32'hFCFCFCFC);
        wait_to(5);  do_load(16'h1234, 4'b0000);
        wait_to(16); exp_frame(0, 1, 0, 15, 32'h60DAF266);
        wait_to(19); do_load(16'hAAAA, 4'b0000);
        wait_to(25); do_load(16'h5555, 4'b0000);
        wait_to(32); exp_frame(0, 2, 0, 15, 32'hB6B6B6B6);
        wait_to(47); do_load(16'h9876, 4'b0000);
        exp_frame(0, 3, 0, 15, 32'hF6FEE0BE);
        if_a.lz_suppress = 1'b1;
        wait_to(50); do_load(16'h0050, 4'b0000);
        wait_to(64); exp_frame(0, 4, 0, 15, 32'h0000B6FC);
        wait_to(70); do_load(16'h0000, 4'b0011);
        wait_to(80); exp_frame(0, 5, 0, 15, 32'h000000FD);
        wait_to(85); do_load(16'h1234, 4'b0000);
        wait_to(96);
        if_a.lz_suppress = 1'b0;
        if_a.digit_en    = 4'b1011;
        exp_frame(0, 6, 0, 15, 32'h6000F266);
        wait_to(112);
        if_a.digit_en = 4'hF;
        exp_frame(0, 7, 0, 9, 32'h60DAF266);
        wait_to(113); do_load(16'hFFFF, 4'b0000);
        wait_to(122);
        rst = 1'b1;
        exp_reset_cycle();
        @(posedge clk);
        #1;
        rst  = 1'b0;
        base = cyc;

        if_a.blink_mask = 4'b0001;
        exp_frame(0, 0, 0, 15, 32'hFCFCFCFC);
        exp_frame(1, 0, 0, 15, 32'hFCFCFCFC);
        wait_to(2); do_load(16'h0008, 4'b0001);
        for (int f = 1; f <= 5; f++) begin
            wait_to(16 * f);
            exp_frame(0, f, 0, 15, (f == 2 || f == 3) ? 32'hFCFCFC00 : 32'hFCFCFCFF);
            if (f == 1) exp_frame(1, 1, 0, 15, 32'hFCFCFCFF);
        end
        wait_to(100);

        if (exp_a_q.size() + exp_b_q.size() > 0) begin
            $display("FAIL leftover got %0d unchecked entries expected 0",
                     exp_a_q.size() + exp_b_q.size());
            n_checks += exp_a_q.size() + exp_b_q.size();
            n_fail   += exp_a_q.size() + exp_b_q.size();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Parametrised multiplexed 7-segment display controller. Time-multiplexes DIGITS hex digits onto one shared segment bus, one digit slot at a time. Adds features beyond a fixed 8-digit scanner: per-digit decimal points, enable and blink masks, leading-zero suppression, anti-ghosting dead time, frame-synchronous tear-free data update, and selectable output polarity. Sits in the IO subsystem between the MMIO display register and the board pins.

Parameters:
DIGITS, 8, number of digits (1..8)
SCAN_DIV, 100000, clk cycles per digit slot (>= DEAD_CYC+1)
DEAD_CYC, 1000, cycles per slot with all digits blanked, at the start of the slot (0..SCAN_DIV-1)
BLINK_FRAMES, 64, full frames per blink half-period (>= 1)
SEG_ACTIVE_LOW, 0, 1 = seg_out inverted
EN_ACTIVE_LOW, 0, 1 = seg_en inverted

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
data_in  in  4*DIGITS  hex nibbles; nibble i = digit i (digit 0 = rightmost)
dp_in  in  DIGITS  decimal point per digit
digit_en  in  DIGITS  0 = digit always blank
blink_mask  in  DIGITS  1 = digit blinks
lz_suppress  in  1  leading-zero suppression enable
load  in  1  one-cycle strobe; capture data_in/dp_in
seg_en  out  DIGITS  one-hot digit select
seg_out  out  8  {a,b,c,d,e,f,g,dp}, bit7 = a, bit0 = dp
frame_done  out  1  one-cycle pulse at the end of each frame

Behaviour:
- Clock: one clock, clk. Reset: rst, synchronous, active-high.
- State registers:
  - slot counter c (0..SCAN_DIV-1)
  - digit index idx (0..DIGITS-1)
  - staging regs plus pending flag
  - shadow regs (displayed data)
  - frame counter (0..BLINK_FRAMES-1)
  - blink phase bp (0 = visible)
- Reset: c=0, idx=0, shadow=0, staging=0, pending=0, frame counter=0, bp=0.
  - Outputs blank (all inactive levels) during the cycle rst is high.
  - frame_done=0.
- Scan:
  - c increments each cycle.
  - At c==SCAN_DIV-1: c wraps to 0 and idx increments.
  - idx wraps DIGITS-1 -> 0.
  - Frame = DIGITS*SCAN_DIV cycles.
- Slot phases:
  - BLANK while c < DEAD_CYC: seg_en and seg_out inactive.
  - SHOW otherwise.
- SHOW drive:
  - seg_en one-hot at idx.
  - seg_out = decode(shadow nibble idx) | dp.
- Digit blanking in SHOW: seg_en stays asserted and seg_out is inactive if any of:
  - digit_en[idx]=0
  - blink_mask[idx]=1 and bp=1
  - leading-zero suppressed
- Leading-zero suppression (lz_suppress=1):
  - Digit i is suppressed if its shadow nibble and all higher nibbles are 0.
  - Digit 0 is never suppressed.
  - The dp of a suppressed digit is also blanked.
- Decode (active-high): 0 FC, 1 60, 2 DA, 3 F2, 4 66, 5 B6, 6 BE, 7 E0, 8 FE, 9 F6, A EE, b 3E, C 9C, d 7A, E 9E, F 8E. dp = bit0.
- Polarity:
  - SEG_ACTIVE_LOW inverts all 8 seg_out bits, including the blank value.
  - EN_ACTIVE_LOW likewise inverts seg_en.
- Outputs are decoded only from registered state; there is no combinational path from data_in, dp_in or load to the outputs.
- Frame end = cycle where idx==DIGITS-1 and c==SCAN_DIV-1. On that cycle:
  - frame_done=1.
  - If pending: shadow <= staging, pending <= 0.
  - Frame counter increments; on wrap, bp toggles.
- load:
  - Captures data_in and dp_in into staging and sets pending.
  - A load on the frame-end cycle commits that same data directly to shadow; pending stays 0.
  - Multiple loads within one frame: last one wins.
  - New data first appears at slot 0 of the next frame; there is never a mixed frame.
- digit_en and blink_mask are sampled live, not shadowed.
- rst mid-frame: state returns to reset values on the next edge; pending data is discarded.

Test Plan:
- Params for all scenarios: DIGITS=4, SCAN_DIV=4, DEAD_CYC=1, BLINK_FRAMES=2, active-high, digit_en=F, lz_suppress=0.
- Reset then release -> seg_en=0 at c=0. At c=1..3, seg_en=0001, seg_out=FC. Each slot shows FC. frame_done pulses every 16 cycles.
- load data_in=0x1234 at cycle 5 -> slots of the current frame still show FC. The next frame shows digit0=66, digit1=F2, digit2=DA, digit3=60. Loads 0xAAAA then 0x5555 in one frame -> next frame shows all B6.
- lz_suppress=1, data 0x0050 -> digit3 and digit2 have seg_out=00 with seg_en asserted; digit1=B6; digit0=FC. Data 0x0000 -> only digit0 shows FC.
- blink_mask=0001, data 0x0008 -> digit0 shows FE in frames 0-1, 00 in frames 2-3, FE in frames 4-5. Other digits are unaffected.
- SEG_ACTIVE_LOW=1, EN_ACTIVE_LOW=1, data 0x0008, dp_in=0001 -> in SHOW of slot 0: seg_out=00, seg_en=1110. BLANK phase: seg_out=FF, seg_en=1111.
- rst asserted at idx=2, c=2, with a load pending -> next cycle: blank outputs, idx=0, c=0. After release, the display shows 0 (FC), not the pending data.
